// File: rtl/mips_dbg_pkg.sv
// Shared constants and FSM state type for the MIPS debug controller.
// Latency: none; this package holds only definitions.
// Backpressure: none; this package holds only definitions.
// Optional feature macro: MIPS_DBG_CYCLE_CNT_EN adds the ST_CNT_TX state.
package mips_dbg_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_DUMP = 8'h04;

    localparam logic [7:0] RSP_ACK  = 8'hA5;
    localparam logic [7:0] RSP_OVF  = 8'hEF;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_BYTE,
        ST_LOAD_WR,
        ST_RUN,
        ST_STEP,
        ST_DUMP_REQ,
        ST_DUMP_TX,
        ST_PC_TX,
`ifdef MIPS_DBG_CYCLE_CNT_EN
        ST_CNT_TX,
`endif
        ST_RESP
    } dbg_state_t;

endpackage

// File: rtl/dbg_word_tx.sv
// Serializes one 32-bit word into 4 bytes, MSB first, over a valid/ready byte link.
// Latency: first byte is valid 1 cycle after i_load; each byte takes one accepted cycle.
// Backpressure: data/valid hold while i_tx_ready is low; o_done pulses with the 4th accepted byte.
// Ports: i_clk, i_reset (async, active high), i_load/i_word (start a word),
//        o_tx_data/o_tx_valid/i_tx_ready (byte link), o_done (last byte accepted).
module dbg_word_tx (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_done
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic        r_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_word  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && i_tx_ready) begin
            // Shifting zeros in leaves the data bus at 0 once the word is drained.
            r_word <= {r_word[23:0], 8'h00};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_tx_data  = r_word[31:24];
    assign o_tx_valid = r_valid;
    assign o_done     = r_valid && i_tx_ready && (r_cnt == 2'd3);

endmodule

// File: rtl/mips_debug_ctrl.sv
// Byte-command debug controller: loads IMEM, runs/steps the CPU, dumps registers and PC.
// Latency: commands are decoded the cycle after the byte arrives; responses are registered.
// Backpressure: tx bytes hold until i_tx_ready; rx bytes outside IDLE/LOAD_BYTE are dropped.
// Ports: i_clk, i_reset (async, active high), i_rx_* (command link), o_tx_*/i_tx_ready (response link),
//        o_cpu_enable/o_cpu_reset, o_imem_* (IMEM write), o_reg_addr/i_reg_data/i_pc/i_halt (debug), o_busy.
// Optional feature macro: MIPS_DBG_CYCLE_CNT_EN appends a 32-bit enable-cycle counter to DUMP.
module mips_debug_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int NB_ADDR    = 32,
    parameter int NB_INST    = 32,
    parameter int NB_DATA    = 32,
    parameter int NB_REG     = 5,
    parameter int IMEM_DEPTH = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_cpu_enable,
    output logic               o_cpu_reset,
    output logic               o_imem_write,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_INST-1:0] o_imem_data,
    output logic [NB_REG-1:0]  o_reg_addr,
    input  logic [NB_DATA-1:0] i_reg_data,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic               i_halt,
    output logic               o_busy
);

    localparam logic [NB_ADDR-1:0] LOAD_LIMIT = NB_ADDR'(4 * IMEM_DEPTH);

    dbg_state_t         r_state;
    logic [1:0]         r_byte_cnt;
    logic [NB_INST-1:0] r_word;
    logic [NB_ADDR-1:0] r_load_addr;
    logic               r_imem_write;
    logic [NB_ADDR-1:0] r_imem_addr;
    logic [NB_INST-1:0] r_imem_data;
    logic               r_cpu_enable;
    logic               r_cpu_reset;
    logic [NB_REG-1:0]  r_reg_addr;
    logic               r_rsp_vld;
    logic [7:0]         r_rsp_dat;
    logic               r_ser_load;
    logic [31:0]        r_ser_word;

    logic [7:0]         w_ser_data;
    logic               w_ser_valid;
    logic               w_ser_done;
    logic               w_cpu_enable;

    // Gate with i_halt so the enable is already low in the cycle the halt is seen.
    assign w_cpu_enable = r_cpu_enable && !i_halt;

`ifdef MIPS_DBG_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic        w_exec_start;

    assign w_exec_start = (r_state == ST_IDLE) && i_rx_valid &&
                          ((i_rx_data == CMD_RUN) || (i_rx_data == CMD_STEP));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cycle_cnt <= '0;
        end else if (w_exec_start) begin
            r_cycle_cnt <= '0;
        end else if (w_cpu_enable && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_load_addr  <= '0;
            r_imem_write <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_cpu_enable <= 1'b0;
            r_cpu_reset  <= 1'b0;
            r_reg_addr   <= '0;
            r_rsp_vld    <= 1'b0;
            r_rsp_dat    <= '0;
            r_ser_load   <= 1'b0;
            r_ser_word   <= '0;
        end else begin
            r_imem_write <= 1'b0;
            r_ser_load   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                r_state     <= ST_LOAD_BYTE;
                                r_cpu_reset <= 1'b1;
                                r_load_addr <= '0;
                                r_byte_cnt  <= '0;
                            end
                            CMD_RUN: begin
                                r_state      <= ST_RUN;
                                r_cpu_enable <= 1'b1;
                            end
                            CMD_STEP: begin
                                r_state      <= ST_STEP;
                                r_cpu_enable <= 1'b1;
                            end
                            CMD_DUMP: begin
                                r_state    <= ST_DUMP_REQ;
                                r_reg_addr <= '0;
                            end
                            default: begin
                                r_state   <= ST_RESP;
                                r_rsp_vld <= 1'b1;
                                r_rsp_dat <= RSP_ERR;
                            end
                        endcase
                    end
                end
                ST_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        r_word     <= {r_word[NB_INST-9:0], i_rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state <= ST_LOAD_WR;
                        end
                    end
                end
                ST_LOAD_WR: begin
                    if (r_load_addr == LOAD_LIMIT) begin
                        // IMEM is full: the word is discarded and the load ends.
                        r_state   <= ST_RESP;
                        r_rsp_vld <= 1'b1;
                        r_rsp_dat <= RSP_OVF;
                    end else begin
                        r_imem_write <= 1'b1;
                        r_imem_addr  <= r_load_addr;
                        r_imem_data  <= r_word;
                        r_load_addr  <= r_load_addr + NB_ADDR'(4);
                        if (r_word == NB_INST'(HALT_WORD)) begin
                            r_state   <= ST_RESP;
                            r_rsp_vld <= 1'b1;
                            r_rsp_dat <= RSP_ACK;
                        end else begin
                            r_state <= ST_LOAD_BYTE;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        r_cpu_enable <= 1'b0;
                        r_state      <= ST_RESP;
                        r_rsp_vld    <= 1'b1;
                        r_rsp_dat    <= RSP_ACK;
                    end
                end
                ST_STEP: begin
                    r_cpu_enable <= 1'b0;
                    r_state      <= ST_RESP;
                    r_rsp_vld    <= 1'b1;
                    r_rsp_dat    <= RSP_ACK;
                end
                ST_DUMP_REQ: begin
                    // o_reg_addr has been stable for a full cycle, so the async read is settled.
                    r_ser_word <= 32'(i_reg_data);
                    r_ser_load <= 1'b1;
                    r_state    <= ST_DUMP_TX;
                end
                ST_DUMP_TX: begin
                    if (w_ser_done) begin
                        if (r_reg_addr == '1) begin
                            r_ser_word <= 32'(i_pc);
                            r_ser_load <= 1'b1;
                            r_state    <= ST_PC_TX;
                        end else begin
                            r_reg_addr <= r_reg_addr + NB_REG'(1);
                            r_state    <= ST_DUMP_REQ;
                        end
                    end
                end
                ST_PC_TX: begin
                    if (w_ser_done) begin
`ifdef MIPS_DBG_CYCLE_CNT_EN
                        r_ser_word <= r_cycle_cnt;
                        r_ser_load <= 1'b1;
                        r_state    <= ST_CNT_TX;
`else
                        r_state    <= ST_IDLE;
`endif
                    end
                end
`ifdef MIPS_DBG_CYCLE_CNT_EN
                ST_CNT_TX: begin
                    if (w_ser_done) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                ST_RESP: begin
                    // CPU reset (held since LOAD) is released only once the response is taken.
                    if (i_tx_ready) begin
                        r_rsp_vld   <= 1'b0;
                        r_rsp_dat   <= '0;
                        r_cpu_reset <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dbg_word_tx u_word_tx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (r_ser_load),
        .i_word     (r_ser_word),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (w_ser_data),
        .o_tx_valid (w_ser_valid),
        .o_done     (w_ser_done)
    );

    // The serializer and the single-byte response are never active together.
    assign o_tx_valid   = r_rsp_vld || w_ser_valid;
    assign o_tx_data    = r_rsp_vld ? r_rsp_dat : w_ser_data;
    assign o_cpu_enable = w_cpu_enable;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_imem_write = r_imem_write;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_data  = r_imem_data;
    assign o_reg_addr   = r_reg_addr;
    assign o_busy       = (r_state != ST_IDLE);

endmodule
